arb_wrr: RTL and testbench
==========================

Name: arb_wrr

Overview:
- Weighted round-robin arbiter that shares one downstream resource between N_REQ requesters.
- It is the successor to the plain 4-way arbiter. It uses the same clock, rst and req/gnt signalling, and adds per-requester burst weights (quotas), back-to-back handoff and a busy/grant-id status.
- It sits between the requester agents and the shared resource. The same interface-based environment (driver, monitor, scoreboard) verifies it.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- WGT_W, 4, width of each weight field; max burst is 2^WGT_W-1 cycles.
- DEFAULT_WGT, 1, weight loaded into every requester at reset.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  request vector; bit i = requester i+1; level-sensitive.
- wgt_cfg  in  N_REQ*WGT_W  weight fields; field i in bits [i*WGT_W +: WGT_W].
- cfg_load  in  1  1-cycle strobe; latches wgt_cfg into the weight registers.
- gnt  out  N_REQ  registered grant vector; one-hot or all-zero.
- gnt_id  out  $clog2(N_REQ)  index of the current grantee; holds its last value when idle.
- busy  out  1  high while any grant is active (equals |gnt).

Behaviour:
- Reset (async, immediate):
  - gnt=0, gnt_id=0, busy=0, FSM=IDLE.
  - Rotation pointer ptr=0, so requester 0 has first priority.
  - Credit counter cnt=0; all weights = DEFAULT_WGT.
  - Reset mid-grant drops gnt in the same cycle rst rises, not on the next edge.
- Weights:
  - On any edge with cfg_load=1, all weight registers load from wgt_cfg.
  - A new weight takes effect at the next grant start. The current burst keeps its loaded credit.
  - A weight field of 0 is treated as 1.
- Pick function: the first set bit of req searching ptr, ptr+1, ..., ptr+N_REQ-1 (mod N_REQ).
- FSM state IDLE:
  - If req!=0 at an edge, go to GRANT with g=pick(req). Set gnt=1<<g, gnt_id=g, cnt=weight[g]-1.
  - Latency: req sampled high at edge k gives gnt high after edge k (one-cycle registered latency).
- FSM state GRANT (grantee g), evaluated at each edge:
  - Hold: req[g]=1 and cnt!=0 → keep gnt, cnt=cnt-1.
  - Release: req[g]=0, or cnt==0 → set ptr=(g+1) mod N_REQ and re-arbitrate in the same edge using the new ptr.
    - If req has any bit set, move directly to the new grantee, with no idle cycle between grants.
    - If req is all-zero, go to IDLE with gnt=0.
  - A lone requester whose quota expires is re-granted immediately (rotation wraps back to g) with fresh credit, so gnt stays continuously high.
  - req[g] dropping gives gnt[g] low after that edge, i.e. one trailing cycle of grant.
- Invariants:
  - gnt is never multi-hot.
  - busy == |gnt.
  - gnt_id matches gnt whenever busy=1.
  - No requester continuously requesting waits more than the sum of the other requesters' weights plus N_REQ cycles.
- Simultaneous events:
  - When cfg_load and a grant start occur on the same edge, the new grant uses the old weight.
  - A req change on the release edge is honoured by that edge's pick.

Decomposition:
- Package arb_pkg:
  - N_REQ and WGT_W defaults.
  - State enum {IDLE, GRANT}.
  - Typedefs: req_vec_t, wgt_t, idx_t.
  - Function to extract weight field i.
- Sub-module arb_rr_pick: combinational rotating priority encoder.
  - Inputs: req, ptr.
  - Outputs: idx, valid.
  - It is reused by the next-state logic and the bench reference model.

Test Plan:
- Reset mid-grant: req=0001 held; rst pulsed at t=47 → gnt=0 at t=47 (async). After release, gnt=0001 one edge after the first sampled req.
- Lone requester: weights all 1, req=0100 held 10 cycles → gnt=0100 continuous from the cycle after req, gnt_id=2, busy=1 throughout.
- Weighted rotation: cfg_load with weights {req1=2, req2=1, req3=1, req4=3}, req=1111 held → gnt sequence per cycle 0001,0001,0010,0100,1000,1000,1000,0001,... with no idle cycles.
- Early release: weights all 4, req=0011, req1 dropped after 2 grant cycles → gnt 0001 for 2 cycles, then 0010 on the next edge. Next, ptr=1 and req2 is served for 4 cycles.
- Zero weight plus mid-burst config: weight 0 for req3 and req=0100 → bursts of 1 (continuous regrant). cfg_load weight 5 mid-burst → the current burst is unaffected and the next grant start holds 5 cycles, checked with req=1100.
- Idle return: req=1000 for 3 cycles then 0 → gnt=1000 for 3 cycles, then gnt=0 and busy=0. gnt_id stays 3.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and defaults for the weighted round-robin arbiter.
// The typedefs are sized for the default configuration.
package arb_pkg;

   localparam int ARB_N_REQ = 4;
   localparam int ARB_WGT_W = 4;
   localparam int ARB_IDX_W = $clog2(ARB_N_REQ);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   typedef logic [ARB_N_REQ-1:0] req_vec_t;
   typedef logic [ARB_WGT_W-1:0] wgt_t;
   typedef logic [ARB_IDX_W-1:0] idx_t;

   function automatic wgt_t wgt_field(input logic [ARB_N_REQ*ARB_WGT_W-1:0] cfg,
                                      input idx_t i);
      return cfg[i*ARB_WGT_W +: ARB_WGT_W];
   endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Rotating priority encoder: first set bit of req starting at ptr, wrapping.
module arb_rr_pick
   import arb_pkg::*;
#(
   parameter int N_REQ = ARB_N_REQ,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   logic [IDX_W:0] pos;

   always_comb begin
      idx   = '0;
      valid = 1'b0;
      pos   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         // Extra bit lets the modulo be a single conditional subtract.
         pos = {1'b0, ptr} + (IDX_W+1)'(i);
         if (pos >= (IDX_W+1)'(N_REQ)) begin
            pos = pos - (IDX_W+1)'(N_REQ);
         end
         if (!valid && req[pos[IDX_W-1:0]]) begin
            valid = 1'b1;
            idx   = pos[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/arb_wrr.sv
// Weighted round-robin arbiter: each grantee keeps the resource for up to
// its weight in cycles, then the rotation moves on with no idle gap.
module arb_wrr
   import arb_pkg::*;
#(
   parameter int N_REQ       = ARB_N_REQ,
   parameter int WGT_W       = ARB_WGT_W,
   parameter int DEFAULT_WGT = 1,
   localparam int IDX_W      = $clog2(N_REQ)
) (
   input  logic                   clock,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WGT_W-1:0] wgt_cfg,
   input  logic                   cfg_load,
   output logic [N_REQ-1:0]       gnt,
   output logic [IDX_W-1:0]       gnt_id,
   output logic                   busy
);

   state_e             state_q, state_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [IDX_W-1:0]   gid_q, gid_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [WGT_W-1:0]   cnt_q, cnt_d;
   logic [WGT_W-1:0]   wgt_q [N_REQ];
   logic [IDX_W-1:0]   nxt_ptr, ptr_sel, pick_idx;
   logic               pick_vld;

   function automatic logic [WGT_W-1:0] burst_len(input logic [WGT_W-1:0] w);
      return (w == '0) ? WGT_W'(1) : w;
   endfunction

   // On release the search starts just past the current grantee, so a lone
   // requester wraps back to itself and is re-granted on the same edge.
   assign nxt_ptr = (gid_q == IDX_W'(N_REQ-1)) ? '0 : gid_q + 1'b1;
   assign ptr_sel = (state_q == GRANT) ? nxt_ptr : ptr_q;

   arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req   (req),
      .ptr   (ptr_sel),
      .idx   (pick_idx),
      .valid (pick_vld)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      gid_d   = gid_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      if (state_q == GRANT && req[gid_q] && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end else begin
         if (state_q == GRANT) begin
            ptr_d = nxt_ptr;
         end
         if (pick_vld) begin
            state_d = GRANT;
            gnt_d   = N_REQ'(1) << pick_idx;
            gid_d   = pick_idx;
            cnt_d   = burst_len(wgt_q[pick_idx]) - 1'b1;
         end else begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         gid_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         gid_q   <= gid_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Grant start reads the pre-edge weights, so a coincident load applies next time.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_REQ; i++) begin
            wgt_q[i] <= WGT_W'(DEFAULT_WGT);
         end
      end else if (cfg_load) begin
         for (int i = 0; i < N_REQ; i++) begin
            wgt_q[i] <= wgt_cfg[i*WGT_W +: WGT_W];
         end
      end
   end

   assign gnt    = gnt_q;
   assign gnt_id = gid_q;
   assign busy   = |gnt_q;

endmodule

// File: tb/tb_arb_wrr.sv
// Directed bench for arb_wrr: hand-computed grant sequences for reset,
// quotas, early release, zero weight, mid-burst config and idle return.
module tb_arb_wrr;
   import arb_pkg::*;

   logic        clock;
   logic        rst;
   req_vec_t    req;
   logic [15:0] wgt_cfg;
   logic        cfg_load;
   logic [3:0]  gnt;
   logic [1:0]  gnt_id;
   logic        busy;

   int n_cmp;
   int n_bad;

   arb_wrr #(.N_REQ(4), .WGT_W(4), .DEFAULT_WGT(1)) dut (
      .clock    (clock),
      .rst      (rst),
      .req      (req),
      .wgt_cfg  (wgt_cfg),
      .cfg_load (cfg_load),
      .gnt      (gnt),
      .gnt_id   (gnt_id),
      .busy     (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic expect_g(input string tag, input logic [3:0] g, input logic [1:0] id);
      check({tag, "_gnt"}, 32'(gnt), 32'(g));
      check({tag, "_busy"}, 32'(busy), 32'(|g));
      check({tag, "_id"}, 32'(gnt_id), 32'(id));
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_rst();
      #1 rst = 1'b1;
      #1 rst = 1'b0;
   endtask

   logic [3:0] rot_g  [10] = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0010};
   logic [1:0] rot_id [10] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1};
   logic [3:0] er_g   [6]  = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
   logic [1:0] er_id  [6]  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      rst      = 1'b0;
      req      = '0;
      wgt_cfg  = '0;
      cfg_load = 1'b0;

      // Reset, then a lone requester granted one edge after being sampled.
      #1 rst = 1'b1;
      #1;
      expect_g("reset", 4'b0000, 2'd0);
      rst = 1'b0;
      req = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_g("rst_hold", 4'b0001, 2'd0);
      end
      // Now at t=46: async reset at t=47 must drop gnt before the next edge.
      #1 rst = 1'b1;
      #1;
      expect_g("rst_async", 4'b0000, 2'd0);
      rst = 1'b0;
      tick();
      expect_g("rst_regrant", 4'b0001, 2'd0);
      req = '0;
      tick();
      expect_g("rst_idle", 4'b0000, 2'd0);

      // Lone requester, weight 1: continuous regrant.
      req = 4'b0100;
      for (int i = 0; i < 10; i++) begin
         tick();
         expect_g("lone", 4'b0100, 2'd2);
      end
      req = '0;
      tick();
      expect_g("lone_end", 4'b0000, 2'd2);

      // Weighted rotation {2,1,1,3}.
      pulse_rst();
      wgt_cfg  = 16'h3112;
      cfg_load = 1'b1;
      tick();
      expect_g("rot_cfg", 4'b0000, 2'd0);
      cfg_load = 1'b0;
      req      = 4'b1111;
      for (int i = 0; i < 10; i++) begin
         tick();
         expect_g($sformatf("rot%0d", i), rot_g[i], rot_id[i]);
      end
      req = '0;
      tick();
      expect_g("rot_end", 4'b0000, 2'd1);

      // Early release with all weights 4.
      pulse_rst();
      wgt_cfg  = 16'h4444;
      cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      req      = 4'b0011;
      for (int i = 0; i < 6; i++) begin
         tick();
         expect_g($sformatf("early%0d", i), er_g[i], er_id[i]);
         if (i == 1) req = 4'b0010;
      end
      req = '0;
      tick();
      expect_g("early_end", 4'b0000, 2'd1);

      // Zero weight on req3 gives bursts of one.
      pulse_rst();
      wgt_cfg  = 16'h1011;
      cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      req      = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_g("zero_w", 4'b0100, 2'd2);
      end
      // Load weight 5 on the edge that re-grants req3: that grant keeps old credit.
      wgt_cfg  = 16'h1511;
      cfg_load = 1'b1;
      tick();
      expect_g("cfg_same_edge", 4'b0100, 2'd2);
      cfg_load = 1'b0;
      req      = 4'b1100;
      tick();
      expect_g("cfg_old_burst", 4'b1000, 2'd3);
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_g($sformatf("w5_%0d", i), 4'b0100, 2'd2);
      end
      tick();
      expect_g("w5_after", 4'b1000, 2'd3);

      // Idle return: gnt_id holds its last value.
      req = '0;
      tick();
      expect_g("idle0", 4'b0000, 2'd3);
      req = 4'b1000;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_g("idle_req", 4'b1000, 2'd3);
      end
      req = '0;
      tick();
      expect_g("idle1", 4'b0000, 2'd3);
      tick();
      expect_g("idle2", 4'b0000, 2'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
